// File: rtl/vec_mem_sequencer.sv
// Strided vector load/store sequencer feeding a single-port scratch RAM.
// Define VEC_MEM_STRIDE_EN to honour cmd_stride; otherwise the stride is fixed at 1.
module vec_mem_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_store,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH-1:0] cmd_stride,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  ld_valid,
    input  logic                  ld_ready,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_last,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy,
    output logic                  done
);

    // state   | meaning
    // IDLE    | waiting for a command
    // LOAD    | reading RAM into the load output register
    // STORE   | writing accepted store elements into RAM
    // FINISH  | one-cycle done pulse
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_FINISH} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] ld_data_q, ld_data_d;
    logic                  ld_valid_q, ld_valid_d;
    logic                  ld_last_q, ld_last_d;
    logic [ADDR_WIDTH-1:0] stride_eff;
    logic                  capture;

`ifdef VEC_MEM_STRIDE_EN
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;

    assign stride_d   = (state_q == S_IDLE && cmd_valid) ? cmd_stride : stride_q;
    assign stride_eff = stride_q;

    always_ff @(posedge clk) begin
        if (!rst_n) stride_q <= '0;
        else        stride_q <= stride_d;
    end
`else
    logic unused_stride;

    assign unused_stride = ^cmd_stride;
    assign stride_eff    = ADDR_WIDTH'(1);
`endif

    // Once the count reaches zero the register holds the last element and no further reads are made.
    assign capture = (state_q == S_LOAD) && (cnt_q != '0) && (!ld_valid_q || ld_ready);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        ld_data_d  = ld_data_q;
        ld_valid_d = ld_valid_q;
        ld_last_d  = ld_last_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_base;
                    cnt_d  = cmd_len;
                    if (cmd_len == '0)  state_d = S_FINISH;
                    else if (cmd_store) state_d = S_STORE;
                    else                state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (ld_valid_q && ld_ready) begin
                    ld_valid_d = 1'b0;
                    ld_last_d  = 1'b0;
                    if (ld_last_q) state_d = S_FINISH;
                end
                if (capture) begin
                    ld_data_d  = mem_rd_data;
                    ld_valid_d = 1'b1;
                    ld_last_d  = (cnt_q == LEN_WIDTH'(1));
                    addr_d     = addr_q + stride_eff;
                    cnt_d      = cnt_q - LEN_WIDTH'(1);
                end
            end
            S_STORE: begin
                if (st_valid) begin
                    addr_d = addr_q + stride_eff;
                    cnt_d  = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
            ld_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            ld_data_q  <= ld_data_d;
            ld_valid_q <= ld_valid_d;
            ld_last_q  <= ld_last_d;
        end
    end

    // Handshake outputs are masked by rst_n so nothing is accepted or written in the reset cycle.
    assign cmd_ready   = rst_n && (state_q == S_IDLE);
    assign st_ready    = rst_n && (state_q == S_STORE);
    assign mem_wr_en   = st_ready && st_valid;
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = (state_q == S_STORE) ? st_data : '0;
    assign mem_rd_addr = addr_q;
    assign ld_valid    = ld_valid_q;
    assign ld_data     = ld_data_q;
    assign ld_last     = ld_last_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FINISH);

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Bench for vec_mem_sequencer: table of commands plus random commands, checked against
// a shadow memory and address arithmetic computed directly from base + i*stride.
module tb_vec_mem_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_store;
    logic [7:0] cmd_base, cmd_stride, cmd_len;
    logic       ld_valid, ld_ready, ld_last;
    logic [7:0] ld_data;
    logic       st_valid, st_ready;
    logic [7:0] st_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_addr, mem_rd_addr, mem_wr_data, mem_rd_data;
    logic       busy, done;

    logic       pl_en;
    logic [7:0] pl_addr, pl_data;
    logic [7:0] ram    [256];
    logic [7:0] shadow [256];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         st;
        logic [7:0] base;
        logic [7:0] stride;
        logic [7:0] len;
        int         mode;      // 0: ready/valid always high, 1: toggle, 2: random
        int         exp_done;  // cycle of done relative to accept, -1 = not checked
    } vec_t;

    vec_t tbl [8];

    vec_mem_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
        .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_len(cmd_len),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en)  ram[mem_wr_addr] <= mem_wr_data;
        else if (pl_en) ram[pl_addr] <= pl_data;
    end
    assign mem_rd_data = ram[mem_rd_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        shadow[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    function automatic logic [7:0] elem_addr(input vec_t v, input int i);
        int s;
`ifdef VEC_MEM_STRIDE_EN
        s = int'(v.stride);
`else
        s = 1;
`endif
        return 8'((int'(v.base) + i * s) % 256);
    endfunction

    task automatic run_cmd(input vec_t v);
        int         idx, first_valid, cyc;
        bit         seen_done, stall_prev, rdy;
        logic [7:0] prev_data, a;
        logic       prev_last;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_store = v.st; cmd_base = v.base;
        cmd_stride = v.stride; cmd_len = v.len;
        ld_ready = 1'b0; st_valid = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        idx = 0; first_valid = -1; seen_done = 0; stall_prev = 0;
        prev_data = '0; prev_last = 1'b0;
        for (cyc = 1; cyc < 400 && !seen_done; cyc++) begin
            if (cyc > 1) @(negedge clk);
            case (v.mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            ld_ready = !v.st && rdy;
            st_valid = v.st && rdy && (idx < int'(v.len));
            st_data  = 8'($urandom);
            #1;
            if (cyc == 1 && !v.st && v.len != 0) check("rd_addr_first", mem_rd_addr, v.base);
            if (stall_prev)
                check("ld_hold", {ld_valid, ld_last, ld_data}, {1'b1, prev_last, prev_data});
            if (!v.st) check("no_wr_in_load", mem_wr_en, 0);
            if (ld_valid && first_valid < 0) begin
                first_valid = cyc;
                check("first_ld_cycle", cyc, 2);
            end
            if (ld_valid && ld_ready) begin
                a = elem_addr(v, idx);
                check("ld_data", ld_data, shadow[a]);
                check("ld_last", ld_last, (idx == int'(v.len) - 1));
                idx++;
            end
            if (v.st) begin
                check("wr_en", mem_wr_en, st_valid);
                if (st_valid) begin
                    a = elem_addr(v, idx);
                    check("wr_addr", mem_wr_addr, a);
                    check("wr_data", mem_wr_data, st_data);
                    shadow[a] = st_data;
                    idx++;
                end
            end
            stall_prev = ld_valid && !ld_ready;
            prev_data  = ld_data;
            prev_last  = ld_last;
            if (done) begin
                seen_done = 1;
                check("elem_count", idx, v.len);
                check("busy_at_done", busy, 1);
                if (v.exp_done >= 0) check("done_cycle", cyc, v.exp_done);
            end
        end
        if (!seen_done) check("done_timeout", 0, 1);
        ld_ready = 1'b0; st_valid = 1'b0;
        @(negedge clk);
        #1;
        check("after_done", {done, busy, cmd_ready}, 3'b001);
    endtask

    initial begin
        int   bad;
        vec_t v;
        rst_n = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        cmd_valid = 1'b0; cmd_store = 1'b0; cmd_base = '0; cmd_stride = '0; cmd_len = '0;
        ld_ready = 1'b0; st_valid = 1'b0; st_data = '0;

        for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
        for (int i = 0; i < 4; i++) preload(8'(8'h10 + i), 8'(8'hA0 + i));
        check("reset_cmd_ready", cmd_ready, 0);
        check("reset_outputs",
              {ld_valid, ld_last, ld_data, st_ready, mem_wr_en, mem_wr_addr, mem_rd_addr,
               mem_wr_data, busy, done}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_cmd_ready", cmd_ready, 1);

        tbl[0] = '{0, 8'h10, 8'h01, 8'd4,  0, 6};
        tbl[1] = '{1, 8'hFE, 8'h01, 8'd3,  0, 4};
        tbl[2] = '{0, 8'h05, 8'hFF, 8'd3,  1, 7};
        tbl[3] = '{0, 8'h33, 8'h01, 8'd0,  0, 1};
        tbl[4] = '{1, 8'h44, 8'h01, 8'd0,  0, 1};
        tbl[5] = '{0, 8'h20, 8'h04, 8'd2,  0, 4};
        tbl[6] = '{1, 8'h80, 8'h03, 8'd6,  2, -1};
        tbl[7] = '{0, 8'hF0, 8'h10, 8'd20, 2, -1};
        for (int t = 0; t < 8; t++) run_cmd(tbl[t]);

        // Reset in the middle of a 5-element store, after two elements have been written.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_store = 1'b1; cmd_base = 8'h40; cmd_stride = 8'h01; cmd_len = 8'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st_valid = 1'b1; st_data = 8'(8'h5A + i);
            #1;
            check("rst_seq_wr_en", mem_wr_en, 1);
            shadow[8'(8'h40 + i)] = st_data;
            @(negedge clk);
        end
        rst_n = 1'b0; st_valid = 1'b1; st_data = 8'hEE;
        #1;
        check("rst_cycle_cmd_ready", cmd_ready, 0);
        check("rst_cycle_no_write", mem_wr_en, 0);
        @(negedge clk);
        check("mid_reset_outputs",
              {ld_valid, ld_last, ld_data, st_ready, mem_wr_en, mem_wr_addr, mem_rd_addr,
               mem_wr_data, busy, done, cmd_ready}, 0);
        rst_n = 1'b1; st_valid = 1'b0;
        @(negedge clk);
        check("mid_reset_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 5; i++)
            check("rst_seq_ram", ram[8'(8'h40 + i)], shadow[8'(8'h40 + i)]);
        v = '{1, 8'h40, 8'h01, 8'd2, 0, 3};
        run_cmd(v);

        for (int r = 0; r < 12; r++) begin
            v.st       = 1'($urandom_range(0, 1));
            v.base     = 8'($urandom);
            v.stride   = 8'($urandom);
            v.len      = 8'($urandom_range(0, 12));
            v.mode     = 2;
            v.exp_done = -1;
            run_cmd(v);
        end

        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== shadow[i]) bad++;
        check("final_ram_contents", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
